// File: rtl/io_out_buffer.sv
// Byte FIFO between the CPU's IO write port and a UART transmitter.
// A halt-port write stops intake and raises prog_end_out once every queued byte has drained.
module io_out_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  io_wr_en_in,
    input  logic                  io_sel_in,
    input  logic [7:0]            io_data_in,
    output logic                  io_full_out,
    output logic [7:0]            tx_data_out,
    output logic                  tx_valid_out,
    input  logic                  tx_ready_in,
    output logic                  prog_end_out,
    output logic [DEPTH_LOG2:0]   count_out
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]     count_reg, count_next;
    logic                    end_req_reg, end_req_next;
    logic                    push, pop, halt_wr;

    // Full is taken from the registered count, so a pop in the same cycle never frees room for a push.
    assign io_full_out  = (count_reg == DEPTH_CNT);
    assign tx_valid_out = (count_reg != '0);
    assign tx_data_out  = mem[rd_ptr_reg];
    assign count_out    = count_reg;

    assign push    = rdy_in & io_wr_en_in & ~io_sel_in & ~io_full_out & ~end_req_reg;
    assign pop     = rdy_in & tx_valid_out & tx_ready_in;
    assign halt_wr = rdy_in & io_wr_en_in & io_sel_in & ~end_req_reg;

    always_comb begin
        wr_ptr_next  = push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
        rd_ptr_next  = pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
        end_req_next = end_req_reg | halt_wr;
        count_next   = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            end_req_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            end_req_reg <= end_req_next;
        end
    end

    // Storage has no reset; only the pointers and count decide what is valid.
    always_ff @(posedge clk_in) begin
        if (push && !rst_in) begin
            mem[wr_ptr_reg] <= io_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (rdy_in) begin
            case (state_reg)
                ST_RUN:   if (halt_wr) state_next = ST_DRAIN;
                // count_next already reflects a pop on this edge.
                ST_DRAIN: if (count_next == '0) state_next = ST_DONE;
                ST_DONE:  state_next = ST_DONE;
                default:  state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        prog_end_out = (state_reg == ST_DONE);
    end
endmodule

// File: tb/tb_io_out_buffer.sv
// Directed bench for io_out_buffer: a byte scoreboard plus a small RUN/DRAIN/DONE model,
// checked with immediate assertions once per clock.
module tb_io_out_buffer;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic                rdy_in = 1'b1;
    logic                io_wr_en_in = 1'b0;
    logic                io_sel_in = 1'b0;
    logic [7:0]          io_data_in = 8'h00;
    logic                io_full_out;
    logic [7:0]          tx_data_out;
    logic                tx_valid_out;
    logic                tx_ready_in = 1'b0;
    logic                prog_end_out;
    logic [DEPTH_LOG2:0] count_out;

    int vectors = 0;
    int miscompares = 0;
    int n_emitted = 0;
    logic [7:0] sb_q [$];
    bit m_end = 1'b0;
    int m_state = 0;

    io_out_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .io_wr_en_in (io_wr_en_in),
        .io_sel_in   (io_sel_in),
        .io_data_in  (io_data_in),
        .io_full_out (io_full_out),
        .tx_data_out (tx_data_out),
        .tx_valid_out(tx_valid_out),
        .tx_ready_in (tx_ready_in),
        .prog_end_out(prog_end_out),
        .count_out   (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: check outputs against the model, advance the model, take the edge, check count.
    task automatic cycle();
        bit push_ok, pop_ok, halt_ok;
        logic [7:0] exp_b;
        chk("tx_valid", 32'(tx_valid_out), 32'(sb_q.size() != 0));
        chk("io_full", 32'(io_full_out), 32'(sb_q.size() == DEPTH));
        chk("prog_end", 32'(prog_end_out), 32'(m_state == 2));
        pop_ok  = !rst_in && rdy_in && tx_ready_in && sb_q.size() != 0;
        push_ok = !rst_in && rdy_in && io_wr_en_in && !io_sel_in && sb_q.size() != DEPTH && !m_end;
        halt_ok = !rst_in && rdy_in && io_wr_en_in && io_sel_in && !m_end;
        if (pop_ok) begin
            exp_b = sb_q.pop_front();
            chk("tx_data", 32'(tx_data_out), 32'(exp_b));
            n_emitted++;
            $display("pop  byte=%02h expected=%02h", tx_data_out, exp_b);
        end
        if (push_ok) begin
            sb_q.push_back(io_data_in);
            $display("push byte=%02h", io_data_in);
        end
        if (halt_ok) m_end = 1'b1;
        if (rst_in) begin
            sb_q.delete();
            m_end = 1'b0;
            m_state = 0;
        end else if (rdy_in) begin
            if (m_state == 0 && halt_ok) m_state = 1;
            else if (m_state == 1 && sb_q.size() == 0) m_state = 2;
        end
        @(posedge clk_in);
        #1;
        chk("count", 32'(count_out), 32'(sb_q.size()));
    endtask

    task automatic idle();
        io_wr_en_in = 1'b0;
        io_sel_in   = 1'b0;
    endtask

    task automatic wr_char(input logic [7:0] b);
        io_wr_en_in = 1'b1;
        io_sel_in   = 1'b0;
        io_data_in  = b;
        cycle();
    endtask

    initial begin
        // reset
        cycle();
        cycle();
        rst_in = 1'b0;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_valid", 32'(tx_valid_out), 32'd0);
        chk("rst_full", 32'(io_full_out), 32'd0);
        chk("rst_prog_end", 32'(prog_end_out), 32'd0);

        // single byte
        tx_ready_in = 1'b1;
        wr_char(8'h41);
        idle();
        chk("single_valid", 32'(tx_valid_out), 32'd1);
        chk("single_data", 32'(tx_data_out), 32'h41);
        cycle();
        chk("single_count", 32'(count_out), 32'd0);

        // fill and overflow
        tx_ready_in = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_char(8'(i));
            if (i == 15) chk("full_after_16", 32'(io_full_out), 32'd1);
        end
        idle();
        chk("fill_count", 32'(count_out), 32'd16);
        tx_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) cycle();
        chk("fill_drained", 32'(count_out), 32'd0);

        // wrap-around
        tx_ready_in = 1'b0;
        for (int i = 0; i < 10; i++) wr_char(8'h80 + 8'(i));
        idle();
        tx_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        tx_ready_in = 1'b0;
        for (int i = 0; i < 12; i++) wr_char(8'hC0 + 8'(i));
        idle();
        chk("wrap_count", 32'(count_out), 32'd12);
        tx_ready_in = 1'b1;
        for (int i = 0; i < 12; i++) cycle();

        // simultaneous push/pop at full: push refused, pop happens
        tx_ready_in = 1'b0;
        for (int i = 0; i < 16; i++) wr_char(8'h20 + 8'(i));
        tx_ready_in = 1'b1;
        wr_char(8'hEE);
        idle();
        chk("full_pushpop_count", 32'(count_out), 32'd15);
        for (int i = 0; i < 15; i++) cycle();

        // halt with pending bytes
        tx_ready_in = 1'b0;
        n_emitted = 0;
        wr_char(8'hA1);
        wr_char(8'hA2);
        wr_char(8'hA3);
        io_wr_en_in = 1'b1;
        io_sel_in   = 1'b1;
        cycle();
        chk("halt_prog_end_low", 32'(prog_end_out), 32'd0);
        wr_char(8'h55);
        idle();
        chk("halt_ignored_char", 32'(count_out), 32'd3);
        tx_ready_in = 1'b1;
        cycle();
        chk("halt_pop1_prog_end", 32'(prog_end_out), 32'd0);
        cycle();
        chk("halt_pop2_prog_end", 32'(prog_end_out), 32'd0);
        cycle();
        chk("halt_pop3_prog_end", 32'(prog_end_out), 32'd1);
        chk("halt_emitted", 32'(n_emitted), 32'd3);
        cycle();

        // rdy_in freeze, then reset mid-drain
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
        chk("rst2_prog_end", 32'(prog_end_out), 32'd0);
        tx_ready_in = 1'b0;
        wr_char(8'h61);
        wr_char(8'h62);
        rdy_in = 1'b0;
        tx_ready_in = 1'b1;
        wr_char(8'h77);
        wr_char(8'h78);
        chk("freeze_count", 32'(count_out), 32'd2);
        idle();
        rdy_in = 1'b1;
        cycle();
        chk("drain_one", 32'(count_out), 32'd1);
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
        chk("rst_mid_count", 32'(count_out), 32'd0);
        chk("rst_mid_valid", 32'(tx_valid_out), 32'd0);
        chk("rst_mid_prog_end", 32'(prog_end_out), 32'd0);

        // halt with empty FIFO: DRAIN after one edge, DONE after the next
        io_wr_en_in = 1'b1;
        io_sel_in   = 1'b1;
        cycle();
        idle();
        chk("halt_empty_drain", 32'(prog_end_out), 32'd0);
        cycle();
        chk("halt_empty_done", 32'(prog_end_out), 32'd1);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
